// File: rtl/bit_serializer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bit_serializer_pkg
// Description : Shared types and helpers for the bit serializer.
//               - state_t   : serializer FSM states (IDLE, SHIFT, PAR)
//               - cnt_width : bit-counter width for a given word width
// Revision    : 1.0 - initial release
// ============================================================================
package bit_serializer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_PAR   = 2'd2
  } state_t;

  // Counter must index 0..width-1; never narrower than one bit.
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bit_serializer_if.sv
`default_nettype none
// ============================================================================
// Module      : bit_serializer_if
// Description : Word-in / bit-out bundle of the bit serializer.
//               din, din_valid, din_ready : parallel word handshake
//               x, x_valid, frame_start   : serial bit stream to the detector
//               busy                      : frame in progress
//               master = word source / bit sink, slave = serializer.
// Revision    : 1.0 - initial release
// ============================================================================
interface bit_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             x;
  logic             x_valid;
  logic             frame_start;
  logic             busy;

  modport master (
    output din, din_valid,
    input  din_ready, x, x_valid, frame_start, busy
  );

  modport slave (
    input  din, din_valid,
    output din_ready, x, x_valid, frame_start, busy
  );
endinterface
`default_nettype wire

// File: rtl/bit_serializer.sv
`default_nettype none
// ============================================================================
// Module      : bit_serializer
// Description : Parallel-in / serial-out stage feeding the 1101 detector.
//               Accepts WIDTH-bit words on a valid/ready handshake and sends
//               them one bit per clock on x, with x_valid and a frame_start
//               pulse on the first bit. Back-to-back words stream gap-free.
// Ports       : clk  - rising-edge clock
//               rst  - asynchronous active-high reset
//               bus  - bit_serializer_if.slave (din/din_valid/din_ready,
//                      x/x_valid/frame_start/busy)
// Options     : BIT_SERIALIZER_PARITY_EN - append an even-parity bit (state
//               PAR) after each frame; din_ready then moves to the PAR cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input wire logic        clk,
  input wire logic        rst,
  bit_serializer_if.slave bus
);

  localparam int                  c_cnt_w = cnt_width(WIDTH);
  localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [c_cnt_w-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic               x_q, x_d;
  logic               x_valid_q, x_valid_d;
  logic               frame_start_q, frame_start_d;
  logic               busy_q, busy_d;
`ifdef BIT_SERIALIZER_PARITY_EN
  logic               parity_q, parity_d;
`endif

  logic w_last_bit;
  logic w_ready;
  logic w_accept;

  // Bit that goes out next from a word, and the word with that bit consumed.
  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

`ifdef BIT_SERIALIZER_PARITY_EN
  assign w_last_bit = (state_q == ST_PAR);
`else
  assign w_last_bit = (state_q == ST_SHIFT) && (cnt_q == c_last);
`endif

  // Ready in the final bit cycle lets the next word start with no gap.
  assign w_ready  = !rst && ((state_q == ST_IDLE) || w_last_bit);
  assign w_accept = bus.din_valid && w_ready;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    shreg_d       = shreg_q;
    x_d           = 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
    parity_d      = parity_q;
`endif

    case (state_q)
      ST_IDLE: begin
        state_d = ST_IDLE;
      end
      ST_SHIFT: begin
        if (cnt_q == c_last) begin
`ifdef BIT_SERIALIZER_PARITY_EN
          state_d = ST_PAR;
          x_d     = parity_q;
`else
          state_d = ST_IDLE;
`endif
        end else begin
          cnt_d   = cnt_q + 1'b1;
          x_d     = first_bit(shreg_q);
          shreg_d = advance(shreg_q);
        end
      end
`ifdef BIT_SERIALIZER_PARITY_EN
      ST_PAR: begin
        state_d = ST_IDLE;
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // An accept can only occur in IDLE or the last bit cycle, so it always
    // overrides the fall-through to IDLE and starts a fresh frame.
    if (w_accept) begin
      state_d  = ST_SHIFT;
      cnt_d    = '0;
      x_d      = first_bit(bus.din);
      shreg_d  = advance(bus.din);
`ifdef BIT_SERIALIZER_PARITY_EN
      parity_d = ^bus.din;
`endif
    end

    x_valid_d     = (state_d != ST_IDLE);
    busy_d        = (state_d != ST_IDLE);
    frame_start_d = w_accept;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      shreg_q       <= '0;
      x_q           <= 1'b0;
      x_valid_q     <= 1'b0;
      frame_start_q <= 1'b0;
      busy_q        <= 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
      parity_q      <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      shreg_q       <= shreg_d;
      x_q           <= x_d;
      x_valid_q     <= x_valid_d;
      frame_start_q <= frame_start_d;
      busy_q        <= busy_d;
`ifdef BIT_SERIALIZER_PARITY_EN
      parity_q      <= parity_d;
`endif
    end
  end

  assign bus.din_ready   = w_ready;
  assign bus.x           = x_q;
  assign bus.x_valid     = x_valid_q;
  assign bus.frame_start = frame_start_q;
  assign bus.busy        = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_bit_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_bit_serializer
// Description : Self-checking bench for bit_serializer (WIDTH=8). An MSB-first
//               instance runs table vectors, streaming, stall and reset cases
//               against a scoreboard; an LSB-first instance runs one frame.
//               Parity expectations follow BIT_SERIALIZER_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_bit_serializer;

  localparam int W = 8;
`ifdef BIT_SERIALIZER_PARITY_EN
  localparam int FL = W + 1;
`else
  localparam int FL = W;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bit_serializer_if #(.WIDTH(W)) bus  ();
  bit_serializer_if #(.WIDTH(W)) bus2 ();

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  typedef struct packed { logic x; logic fs; } sb_t;
  typedef struct { logic [W-1:0] din; logic [W-1:0] bits; logic par; } vec_t;

  sb_t  sb[$];
  sb_t  mon_e;
  logic logv[$], logr[$], logf[$];
  bit   mon_en = 1'b0;
  bit   log_en = 1'b0;
  int   n_chk  = 0;
  int   n_pass = 0;
  vec_t vec[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Scoreboard consumer and cycle logger, sampled mid-cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.x_valid === 1'b1) begin
        check("busy_in_frame", bus.busy, 1);
        if (sb.size() == 0) begin
          check("unexpected_bit", bus.x_valid, 0);
        end else begin
          mon_e = sb.pop_front();
          check("x_bit", bus.x, mon_e.x);
          check("frame_start", bus.frame_start, mon_e.fs);
        end
      end else begin
        check("idle_x", bus.x, 0);
        check("idle_fs", bus.frame_start, 0);
        check("idle_busy", bus.busy, 0);
      end
    end
    if (log_en) begin
      logv.push_back(bus.x_valid);
      logr.push_back(bus.din_ready);
      logf.push_back(bus.frame_start);
    end
  end

  // Present a word, wait for ready, queue its expected bits, cross the edge.
  task automatic send(input logic [W-1:0] w, input logic [W-1:0] exp, input logic p);
    int n = 0;
    bus.din       = w;
    bus.din_valid = 1'b1;
    while (bus.din_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (bus.din_ready !== 1'b1) begin
      check("accept_timeout", bus.din_ready, 1);
    end else begin
      for (int i = 0; i < W; i++) sb.push_back('{x: exp[W-1-i], fs: (i == 0)});
      if (FL > W) sb.push_back('{x: p, fs: 1'b0});
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
  endtask

  task automatic log_start();
    logv.delete();
    logr.delete();
    logf.delete();
    log_en = 1'b1;
  endtask

  task automatic log_stop();
    repeat (2) @(negedge clk);
    #1;
    log_en = 1'b0;
  endtask

  // Two contiguous frames: valid throughout, frame_start at each frame head,
  // din_ready only in each frame's last cycle, idle right after.
  task automatic check_stream(input string tag);
    int i0 = -1;
    foreach (logv[i]) if (i0 < 0 && logv[i] === 1'b1) i0 = i;
    check({tag, "_found"}, (i0 >= 0), 1);
    if (i0 >= 0 && logv.size() < i0 + 2*FL + 1) begin
      check({tag, "_log_len"}, logv.size(), i0 + 2*FL + 1);
    end else if (i0 >= 0) begin
      for (int k = 0; k < 2*FL; k++) begin
        check({tag, "_valid"}, logv[i0+k], 1);
        check({tag, "_fs"}, logf[i0+k], (k == 0 || k == FL));
        check({tag, "_ready"}, logr[i0+k], (k == FL-1 || k == 2*FL-1));
      end
      check({tag, "_end"}, logv[i0+2*FL], 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] lsb_exp;
    int           ones;

    vec[0] = '{8'hD0, 8'b11010000, 1'b1};
    vec[1] = '{8'hC0, 8'b11000000, 1'b0};
    vec[2] = '{8'h81, 8'b10000001, 1'b0};
    vec[3] = '{8'h00, 8'b00000000, 1'b0};
    vec[4] = '{8'hFF, 8'b11111111, 1'b0};
    vec[5] = '{8'h6D, 8'b01101101, 1'b1};

    bus.din        = '0;
    bus.din_valid  = 1'b0;
    bus2.din       = '0;
    bus2.din_valid = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_x", bus.x, 0);
    check("rst_x_valid", bus.x_valid, 0);
    check("rst_frame_start", bus.frame_start, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_din_ready", bus.din_ready, 0);
    #1 rst = 1'b0;
    @(negedge clk);
    check("idle_ready", bus.din_ready, 1);
    mon_en = 1'b1;
    repeat (2) @(negedge clk);

    // Single frames from the table
    for (int r = 0; r < 6; r++) begin
      log_start();
      send(vec[r].din, vec[r].bits, vec[r].par);
      bus.din_valid = 1'b0;
      wait_drain();
      log_stop();
      ones = 0;
      foreach (logv[i]) if (logv[i] === 1'b1) ones++;
      check("frame_len", ones, FL);
    end

    // Streaming with din_valid held high
    log_start();
    send(8'hA5, 8'b10100101, 1'b0);
    send(8'h3C, 8'b00111100, 1'b0);
    bus.din_valid = 1'b0;
    wait_drain();
    log_stop();
    check_stream("stream");

    // Word offered mid-frame waits for the last bit cycle
    log_start();
    send(8'hD0, 8'b11010000, 1'b1);
    bus.din_valid = 1'b0;
    repeat (3) @(negedge clk);
    bus.din       = 8'h81;
    bus.din_valid = 1'b1;
    check("stall_ready_low", bus.din_ready, 0);
    send(8'h81, 8'b10000001, 1'b0);
    bus.din_valid = 1'b0;
    wait_drain();
    log_stop();
    check_stream("stall");

    // Asynchronous reset in the middle of a frame
    send(8'hFF, 8'b11111111, 1'b0);
    bus.din_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("pre_rst_valid", bus.x_valid, 1);
    mon_en = 1'b0;
    rst    = 1'b1;
    #1;
    check("async_rst_x", bus.x, 0);
    check("async_rst_x_valid", bus.x_valid, 0);
    check("async_rst_busy", bus.busy, 0);
    check("async_rst_ready", bus.din_ready, 0);
    sb.delete();
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;
    log_start();
    send(8'h01, 8'b00000001, 1'b1);
    bus.din_valid = 1'b0;
    wait_drain();
    log_stop();
    ones = 0;
    foreach (logv[i]) if (logv[i] === 1'b1) ones++;
    check("post_rst_frame_len", ones, FL);

    // LSB-first instance: 8'h0B -> 1,1,0,1,0,0,0,0
    @(negedge clk);
    check("lsb_ready", bus2.din_ready, 1);
    bus2.din       = 8'h0B;
    bus2.din_valid = 1'b1;
    @(posedge clk);
    #1 bus2.din_valid = 1'b0;
    lsb_exp = 8'b11010000;
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      check("lsb_bit", bus2.x, lsb_exp[W-1-i]);
      check("lsb_valid", bus2.x_valid, 1);
      check("lsb_fs", bus2.frame_start, (i == 0));
    end
    if (FL > W) begin
      @(negedge clk);
      check("lsb_parity", bus2.x, 1);
      check("lsb_parity_valid", bus2.x_valid, 1);
    end
    @(negedge clk);
    check("lsb_end_valid", bus2.x_valid, 0);
    check("lsb_end_x", bus2.x, 0);

    check("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
